seq_stage_controller: RTL and testbench

- Multi-cycle sequencer for the sequential Y86 core.
- Steps each instruction through FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PCUPD, one state at a time.
- Owns the architectural PC register and loads it from the new-PC logic output in PCUPD.
- Tracks processor status (AOK/HLT/ADR/INS), runs the data-memory request handshake, and counts retired instructions.

---
 rtl/seq_stage_controller.sv | 159 +++++++++++++++
 tb/tb_seq_stage_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_stage_controller.sv
// Sequencer for the multi-cycle Y86 core: walks F/D/E/M/W/PCUPD, owns PC, status, dmem handshake, retire count.
// Define SEQ_PC_BREAKPOINT_EN to add a PC breakpoint that parks the core in PAUSE before fetch.
module seq_stage_controller #(
  parameter int                ADDR_W      = 64,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        icode,
  input  logic              instr_invalid,
  input  logic              imem_error,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              mem_ack,
  input  logic              dmem_error,
`ifdef SEQ_PC_BREAKPOINT_EN
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic              bp_valid,
  input  logic              resume,
  output logic              bp_hit,
`endif
  output logic [ADDR_W-1:0] pc,
  output logic [5:0]        stage_en,
  output logic              cc_we,
  output logic              mem_req,
  output logic [2:0]        stat,
  output logic              halted,
  output logic [31:0]       retired
);

  localparam int            TW      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(MEM_TIMEOUT - 1);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALT
`ifdef SEQ_PC_BREAKPOINT_EN
    , S_PAUSE
`endif
  } state_t;

  state_t        state;
  logic [3:0]    icode_q;
  logic [TW-1:0] tmo;

  function automatic logic is_mem(input logic [3:0] ic);
    return (ic == 4'h4) || (ic == 4'h5) || (ic == 4'h8) ||
           (ic == 4'h9) || (ic == 4'hA) || (ic == 4'hB);
  endfunction

  always_comb begin
    stage_en = '0;
    case (state)
      S_FETCH:     stage_en = 6'b000001;
      S_DECODE:    stage_en = 6'b000010;
      S_EXECUTE:   stage_en = 6'b000100;
      S_MEMORY:    stage_en = 6'b001000;
      S_WRITEBACK: stage_en = 6'b010000;
      S_PCUPD:     stage_en = 6'b100000;
      default:     stage_en = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      cc_we   <= 1'b0;
      mem_req <= 1'b0;
      stat    <= STAT_AOK;
      halted  <= 1'b0;
      retired <= '0;
      icode_q <= '0;
      tmo     <= '0;
`ifdef SEQ_PC_BREAKPOINT_EN
      bp_hit  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (start) begin
`ifdef SEQ_PC_BREAKPOINT_EN
          if (bp_valid && pc == bp_addr) begin
            state  <= S_PAUSE;
            bp_hit <= 1'b1;
          end else
`endif
          state <= S_FETCH;
        end
        S_FETCH: begin
          icode_q <= icode;
          // Fault priority: imem address error beats illegal instruction beats halt.
          if (imem_error) begin
            stat <= STAT_ADR; state <= S_HALT; halted <= 1'b1;
          end else if (instr_invalid) begin
            stat <= STAT_INS; state <= S_HALT; halted <= 1'b1;
          end else if (icode == 4'h0) begin
            stat <= STAT_HLT; state <= S_HALT; halted <= 1'b1;
          end else begin
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          cc_we <= (icode_q == 4'h6);
          state <= S_EXECUTE;
        end
        S_EXECUTE: begin
          cc_we   <= 1'b0;
          tmo     <= '0;
          mem_req <= is_mem(icode_q);
          state   <= S_MEMORY;
        end
        S_MEMORY: begin
          if (!mem_req) begin
            state <= S_WRITEBACK;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            if (dmem_error) begin
              stat <= STAT_ADR; state <= S_HALT; halted <= 1'b1;
            end else begin
              state <= S_WRITEBACK;
            end
          end else if (tmo == TO_LAST) begin
            mem_req <= 1'b0;
            stat    <= STAT_ADR; state <= S_HALT; halted <= 1'b1;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        S_WRITEBACK: state <= S_PCUPD;
        S_PCUPD: begin
          pc      <= new_pc;
          retired <= retired + 32'd1;
`ifdef SEQ_PC_BREAKPOINT_EN
          if (bp_valid && new_pc == bp_addr) begin
            state  <= S_PAUSE;
            bp_hit <= 1'b1;
          end else
`endif
          state <= S_FETCH;
        end
        S_HALT: mem_req <= 1'b0;
`ifdef SEQ_PC_BREAKPOINT_EN
        // Resuming skips the address check so the paused instruction can issue.
        S_PAUSE: if (resume) begin
          bp_hit <= 1'b0;
          state  <= S_FETCH;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_stage_controller.sv
// Bench for seq_stage_controller: instruction vector table with a result scoreboard,
// plus hand sequences for the stage walk, halt stickiness and async reset.
module tb_seq_stage_controller;
  localparam int            AW  = 64;
  localparam logic [AW-1:0] RPC = 64'h100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    icode = '0;
  logic          instr_invalid = 1'b0;
  logic          imem_error = 1'b0;
  logic [AW-1:0] new_pc = '0;
  logic          mem_ack = 1'b0;
  logic          dmem_error = 1'b0;
  logic [AW-1:0] pc;
  logic [5:0]    stage_en;
  logic          cc_we;
  logic          mem_req;
  logic [2:0]    stat;
  logic          halted;
  logic [31:0]   retired;

  seq_stage_controller #(.ADDR_W(AW), .RESET_PC(RPC), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .icode(icode),
    .instr_invalid(instr_invalid), .imem_error(imem_error), .new_pc(new_pc),
    .mem_ack(mem_ack), .dmem_error(dmem_error), .pc(pc), .stage_en(stage_en),
    .cc_we(cc_we), .mem_req(mem_req), .stat(stat), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    icode;
    logic          inv, ierr, derr, spur;
    int            ack;   // MEMORY cycle in which mem_ack is raised, 0 = never
    logic [AW-1:0] npc;
    logic [2:0]    stat;
    logic          hlt;
    logic [AW-1:0] pc;
    logic [31:0]   ret;
    int            cyc, req, cc;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl [NV];
  vec_t exp_q [$];
  int   nvec = 0;
  int   nerr = 0;

  function automatic vec_t mk(input logic [3:0] ic, input logic inv, input logic ierr,
                              input logic derr, input logic spur, input int ack,
                              input logic [AW-1:0] npc, input logic [2:0] st, input logic hlt,
                              input logic [AW-1:0] epc, input logic [31:0] ret,
                              input int cyc, input int req, input int cc);
    vec_t v;
    v.icode = ic; v.inv = inv; v.ierr = ierr; v.derr = derr; v.spur = spur; v.ack = ack;
    v.npc = npc; v.stat = st; v.hlt = hlt; v.pc = epc; v.ret = ret;
    v.cyc = cyc; v.req = req; v.cc = cc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    start = 0; icode = 0; instr_invalid = 0; imem_error = 0;
    mem_ack = 0; dmem_error = 0; new_pc = '0;
    @(posedge clk); #2 rst_n = 1'b0; #4 rst_n = 1'b1;
  endtask

  // DUT is sampled in FETCH on entry; runs until the next FETCH or a halt.
  task automatic run_vec(input int idx, input vec_t v);
    int   cyc = 0, memc = 0, reqc = 0, ccc = 0, ccbad = 0, ohbad = 0;
    bit   done = 0;
    vec_t e;
    exp_q.push_back(v);
    icode = v.icode; instr_invalid = v.inv; imem_error = v.ierr; new_pc = v.npc;
    mem_ack = v.spur; dmem_error = v.spur;
    while (!done && cyc < 64) begin
      tick();
      cyc++;
      if ($countones(stage_en) > 1) ohbad++;
      if (cc_we) ccc++;
      if (cc_we && stage_en != 6'h04) ccbad++;
      if (mem_req) reqc++;
      if (stage_en == 6'h08 && mem_req) begin
        memc++;
        if (!v.spur) begin
          mem_ack    = (memc == v.ack);
          dmem_error = (memc == v.ack) && v.derr;
        end
      end else if (!v.spur) begin
        mem_ack = 0; dmem_error = 0;
      end
      if (stage_en == 6'h01 || halted) done = 1;
    end
    mem_ack = 0; dmem_error = 0;
    e = exp_q.pop_front();
    if (!done) begin
      nvec++; nerr++;
      $display("FAIL v%0d timeout: no FETCH/HALT within %0d cycles", idx, cyc);
    end
    chk($sformatf("v%0d stat", idx), stat, e.stat);
    chk($sformatf("v%0d halted", idx), halted, e.hlt);
    chk($sformatf("v%0d pc", idx), pc, e.pc);
    chk($sformatf("v%0d retired", idx), retired, e.ret);
    chk($sformatf("v%0d cycles", idx), cyc, e.cyc);
    chk($sformatf("v%0d mem_req_cycles", idx), reqc, e.req);
    chk($sformatf("v%0d cc_we_cycles", idx), ccc, e.cc);
    chk($sformatf("v%0d cc_we_outside_E", idx), ccbad, 0);
    chk($sformatf("v%0d stage_onehot", idx), ohbad, 0);
    chk($sformatf("v%0d mem_req_end", idx), mem_req, 0);
  endtask

  logic [5:0] walk [6];

  initial begin
    //           ic    inv ierr derr spur ack npc            stat hlt pc             ret cyc req cc
    tbl[0]  = mk(4'h6, 0,  0,   0,   0,   0,  64'h2,         1,   0,  64'h2,         1,  6,  0,  1);
    tbl[1]  = mk(4'h5, 0,  0,   0,   0,   3,  64'hA,         1,   0,  64'hA,         1,  8,  3,  0);
    tbl[2]  = mk(4'h0, 0,  0,   0,   0,   0,  64'h2,         2,   1,  RPC,           0,  1,  0,  0);
    tbl[3]  = mk(4'h6, 1,  0,   0,   0,   0,  64'h2,         4,   1,  RPC,           0,  1,  0,  0);
    tbl[4]  = mk(4'h6, 1,  1,   0,   0,   0,  64'h2,         3,   1,  RPC,           0,  1,  0,  0);
    tbl[5]  = mk(4'hA, 0,  0,   0,   0,   0,  64'h8,         3,   1,  RPC,           0,  19, 16, 0);
    tbl[6]  = mk(4'h4, 0,  0,   1,   0,   2,  64'h8,         3,   1,  RPC,           0,  5,  2,  0);
    tbl[7]  = mk(4'h8, 0,  0,   0,   0,   1,  64'h40,        1,   0,  64'h40,        1,  6,  1,  0);
    tbl[8]  = mk(4'h2, 0,  0,   0,   1,   0,  64'h1234,      1,   0,  64'h1234,      1,  6,  0,  0);
    tbl[9]  = mk(4'h9, 0,  0,   0,   0,   16, 64'h77,        1,   0,  64'h77,        1,  21, 16, 0);
    tbl[10] = mk(4'h3, 0,  1,   0,   0,   0,  64'h2,         3,   1,  RPC,           0,  1,  0,  0);
    tbl[11] = mk(4'hB, 0,  0,   0,   0,   1,  64'h18,        1,   0,  64'h18,        1,  6,  1,  0);
    tbl[12] = mk(4'h7, 0,  0,   0,   0,   0,  64'hFFFF_FFF0, 1,   0,  64'hFFFF_FFF0, 1,  6,  0,  0);
    walk[0] = 6'h01; walk[1] = 6'h02; walk[2] = 6'h04;
    walk[3] = 6'h08; walk[4] = 6'h10; walk[5] = 6'h20;

    // Reset state, and IDLE holds without start.
    do_reset();
    chk("rst stage_en", stage_en, 0);
    chk("rst pc", pc, RPC);
    chk("rst stat", stat, 1);
    chk("rst halted", halted, 0);
    chk("rst retired", retired, 0);
    chk("rst mem_req", mem_req, 0);
    chk("rst cc_we", cc_we, 0);
    tick(); tick();
    chk("idle hold stage_en", stage_en, 0);

    for (int i = 0; i < NV; i++) begin
      do_reset();
      start = 1; tick(); start = 0;
      chk($sformatf("v%0d in_fetch", i), stage_en, 6'h01);
      run_vec(i, tbl[i]);
    end

    // Stage walk with start held high, two OPq back to back.
    do_reset();
    icode = 4'h6; new_pc = 64'h2; start = 1; tick();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("walk%0d stage_en", i), stage_en, walk[i]);
      chk($sformatf("walk%0d cc_we", i), cc_we, (i == 2));
      if (i == 5) new_pc = 64'h2;
      tick();
    end
    chk("walk pc", pc, 64'h2);
    chk("walk retired", retired, 1);
    chk("walk refetch", stage_en, 6'h01);
    new_pc = 64'h30;
    repeat (6) tick();
    chk("walk2 pc", pc, 64'h30);
    chk("walk2 retired", retired, 2);
    chk("walk2 refetch", stage_en, 6'h01);
    start = 0;

    // Halt is sticky: later start pulses change nothing.
    do_reset();
    start = 1; tick(); start = 0;
    icode = 4'h0; tick();
    chk("halt halted", halted, 1);
    start = 1; repeat (3) tick(); start = 0; tick();
    chk("halt2 halted", halted, 1);
    chk("halt2 stat", stat, 2);
    chk("halt2 pc", pc, RPC);
    chk("halt2 retired", retired, 0);
    chk("halt2 stage_en", stage_en, 0);

    // Async reset mid-MEMORY with a request outstanding.
    do_reset();
    start = 1; tick(); start = 0;
    icode = 4'h6; new_pc = 64'h50;
    repeat (6) tick();
    chk("ar retired_pre", retired, 1);
    chk("ar pc_pre", pc, 64'h50);
    icode = 4'h5;
    repeat (3) tick();
    chk("ar in_mem", stage_en, 6'h08);
    chk("ar mem_req_pre", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar mem_req", mem_req, 0);
    chk("ar stage_en", stage_en, 0);
    chk("ar retired", retired, 0);
    chk("ar pc", pc, RPC);
    chk("ar stat", stat, 1);
    #2 rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
